router_fsm: RTL and testbench
=============================

ROUTER_FSM -- requirements
Module: router_fsm

Interface
REQ-001 SHALL have no parameters; state encoding is internal (3-bit).
REQ-002 clock  input  1  rising-edge clock for all state.
REQ-003 resetn  input  1  reset, synchronous, active-low.
REQ-004 pkt_valid  input  1  source asserts while packet bytes (header through payload) are on the bus.
REQ-005 data_in  input  2  header address bits [1:0]; 0/1/2 select output channel, 3 invalid.
REQ-006 fifo_full  input  1  full flag of the currently addressed output FIFO.
REQ-007 fifo_empty_0, fifo_empty_1, fifo_empty_2  input  1 each  empty flags of the three output FIFOs.
REQ-008 soft_reset_0, soft_reset_1, soft_reset_2  input  1 each  per-channel timeout soft resets.
REQ-009 parity_done  input  1  register stage has captured the parity byte.
REQ-010 low_pkt_valid  input  1  register stage indicates pkt_valid fell while a byte was held during full.
REQ-011 detect_add  output  1  header-decode phase.
REQ-012 lfd_state  output  1  loading header (first) byte; drives FIFO header-tag bit.
REQ-013 ld_state  output  1  loading payload bytes.
REQ-014 laf_state  output  1  loading the byte held while FIFO was full.
REQ-015 full_state  output  1  waiting on full FIFO.
REQ-016 write_enb_reg  output  1  register stage may drive FIFO write.
REQ-017 rst_int_reg  output  1  parity-check phase; register stage clears internal parity.
REQ-018 busy  output  1  back-pressure to source; source holds data while high.
REQ-019 addr  output  2  latched channel address.

Function
REQ-020 SHALL implement exactly eight states: DECODE_ADDRESS, LOAD_FIRST_DATA, LOAD_DATA, FIFO_FULL_STATE, LOAD_AFTER_FULL, LOAD_PARITY, CHECK_PARITY_ERROR, WAIT_TILL_EMPTY.
REQ-021 addr SHALL capture data_in when state=DECODE_ADDRESS and pkt_valid=1 and data_in!=3; otherwise hold.
REQ-022 DECODE_ADDRESS: pkt_valid & data_in!=3 & fifo_empty[data_in] -> LOAD_FIRST_DATA; pkt_valid & data_in!=3 & !fifo_empty[data_in] -> WAIT_TILL_EMPTY; else stay (data_in=3 ignored, no addr update).
REQ-023 LOAD_FIRST_DATA -> LOAD_DATA unconditionally (one cycle).
REQ-024 LOAD_DATA: fifo_full -> FIFO_FULL_STATE; else !pkt_valid -> LOAD_PARITY; else stay; fifo_full takes priority.
REQ-025 FIFO_FULL_STATE: fifo_full -> stay; else -> LOAD_AFTER_FULL.
REQ-026 LOAD_AFTER_FULL: parity_done -> DECODE_ADDRESS; else low_pkt_valid -> LOAD_PARITY; else -> LOAD_DATA.
REQ-027 LOAD_PARITY -> CHECK_PARITY_ERROR unconditionally.
REQ-028 CHECK_PARITY_ERROR: fifo_full -> FIFO_FULL_STATE; else -> DECODE_ADDRESS.
REQ-029 WAIT_TILL_EMPTY: fifo_empty[addr] -> LOAD_FIRST_DATA; else stay.
REQ-030 soft_reset[addr]=1 in any state other than DECODE_ADDRESS SHALL force next state DECODE_ADDRESS, overriding REQ-023..029; soft resets of other channels SHALL be ignored.
REQ-031 Outputs SHALL be Moore, decoded from current state only: detect_add=DECODE_ADDRESS, lfd_state=LOAD_FIRST_DATA, ld_state=LOAD_DATA, full_state=FIFO_FULL_STATE, laf_state=LOAD_AFTER_FULL, rst_int_reg=CHECK_PARITY_ERROR.
REQ-032 write_enb_reg SHALL be 1 in LOAD_DATA, LOAD_PARITY, LOAD_AFTER_FULL; 0 elsewhere.
REQ-033 busy SHALL be 1 in all states except DECODE_ADDRESS and LOAD_DATA.
REQ-034 Exactly one of detect_add/lfd_state/ld_state/full_state/laf_state/rst_int_reg SHALL be high, except in LOAD_PARITY and WAIT_TILL_EMPTY where all are 0.
REQ-035 Latency: input change affects outputs one clock later; no combinational input-to-output path.

Reset
REQ-036 resetn=0 at a rising edge SHALL set state=DECODE_ADDRESS and addr=0, overriding soft resets and all transitions, including mid-packet.
REQ-037 After reset: detect_add=1, busy=0, write_enb_reg=0, all other outputs 0.
REQ-038 Unused encodings SHALL recover to DECODE_ADDRESS next cycle.

Verification
REQ-039 Reset, pkt_valid=1, data_in=1, fifo_empty_1=1 -> LOAD_FIRST_DATA (lfd_state=1,busy=1), then LOAD_DATA (ld_state=1,write_enb_reg=1,busy=0), addr=1.
REQ-040 In LOAD_DATA drop pkt_valid, fifo_full=0 -> LOAD_PARITY (write_enb_reg=1,busy=1), CHECK_PARITY_ERROR (rst_int_reg=1), DECODE_ADDRESS.
REQ-041 In LOAD_DATA fifo_full=1 for 3 cycles -> full_state=1 for 3 cycles, then laf_state=1; parity_done=0, low_pkt_valid=1 -> LOAD_PARITY.
REQ-042 Header data_in=2, fifo_empty_2=0 -> WAIT_TILL_EMPTY held (busy=1) until fifo_empty_2=1, then LOAD_FIRST_DATA.
REQ-043 addr=0 in LOAD_DATA: soft_reset_1=1 -> no change; soft_reset_0=1 -> DECODE_ADDRESS next cycle; data_in=3 with pkt_valid=1 -> stays DECODE_ADDRESS.
REQ-044 resetn=0 during FIFO_FULL_STATE with soft_reset_0=1 -> DECODE_ADDRESS, addr=0, detect_add=1.

Source files
------------

// File: rtl/router_fsm.sv
// Router control FSM: decodes the header address, sequences header/payload/parity
// loading into the addressed output FIFO and applies back-pressure to the source.
module router_fsm (
  input  logic       clock,
  input  logic       resetn,
  input  logic       pkt_valid,
  input  logic [1:0] data_in,
  input  logic       fifo_full,
  input  logic       fifo_empty_0,
  input  logic       fifo_empty_1,
  input  logic       fifo_empty_2,
  input  logic       soft_reset_0,
  input  logic       soft_reset_1,
  input  logic       soft_reset_2,
  input  logic       parity_done,
  input  logic       low_pkt_valid,
  output logic       detect_add,
  output logic       lfd_state,
  output logic       ld_state,
  output logic       laf_state,
  output logic       full_state,
  output logic       write_enb_reg,
  output logic       rst_int_reg,
  output logic       busy,
  output logic [1:0] addr
);

  typedef enum logic [2:0] {
    DECODE_ADDRESS     = 3'd0,
    LOAD_FIRST_DATA    = 3'd1,
    LOAD_DATA          = 3'd2,
    FIFO_FULL_STATE    = 3'd3,
    LOAD_AFTER_FULL    = 3'd4,
    LOAD_PARITY        = 3'd5,
    CHECK_PARITY_ERROR = 3'd6,
    WAIT_TILL_EMPTY    = 3'd7
  } state_t;

  state_t     r_state, w_next;
  logic [1:0] r_addr;
  logic [3:0] w_empty, w_soft;
  logic       w_hdr_ok;

  // Entry 3 padded so address 3 indexes a defined zero.
  assign w_empty  = {1'b0, fifo_empty_2, fifo_empty_1, fifo_empty_0};
  assign w_soft   = {1'b0, soft_reset_2, soft_reset_1, soft_reset_0};
  assign w_hdr_ok = pkt_valid && (data_in != 2'd3);

  always_ff @(posedge clock) begin
    if (!resetn) begin
      r_state <= DECODE_ADDRESS;
      r_addr  <= 2'd0;
    end else begin
      r_state <= w_next;
      if (r_state == DECODE_ADDRESS && w_hdr_ok) r_addr <= data_in;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      DECODE_ADDRESS:
        if (w_hdr_ok) w_next = w_empty[data_in] ? LOAD_FIRST_DATA : WAIT_TILL_EMPTY;
      LOAD_FIRST_DATA:    w_next = LOAD_DATA;
      LOAD_DATA:
        if (fifo_full)       w_next = FIFO_FULL_STATE;
        else if (!pkt_valid) w_next = LOAD_PARITY;
      FIFO_FULL_STATE:
        if (!fifo_full) w_next = LOAD_AFTER_FULL;
      LOAD_AFTER_FULL:
        if (parity_done)        w_next = DECODE_ADDRESS;
        else if (low_pkt_valid) w_next = LOAD_PARITY;
        else                    w_next = LOAD_DATA;
      LOAD_PARITY:        w_next = CHECK_PARITY_ERROR;
      CHECK_PARITY_ERROR: w_next = fifo_full ? FIFO_FULL_STATE : DECODE_ADDRESS;
      WAIT_TILL_EMPTY:
        if (w_empty[r_addr]) w_next = LOAD_FIRST_DATA;
      default:            w_next = DECODE_ADDRESS;
    endcase
    // Timeout on the active channel aborts the packet from any busy state.
    if (r_state != DECODE_ADDRESS && w_soft[r_addr]) w_next = DECODE_ADDRESS;
  end

  always_comb begin
    detect_add    = (r_state == DECODE_ADDRESS);
    lfd_state     = (r_state == LOAD_FIRST_DATA);
    ld_state      = (r_state == LOAD_DATA);
    full_state    = (r_state == FIFO_FULL_STATE);
    laf_state     = (r_state == LOAD_AFTER_FULL);
    rst_int_reg   = (r_state == CHECK_PARITY_ERROR);
    write_enb_reg = (r_state == LOAD_DATA) || (r_state == LOAD_PARITY) ||
                    (r_state == LOAD_AFTER_FULL);
    busy          = !((r_state == DECODE_ADDRESS) || (r_state == LOAD_DATA));
  end

  assign addr = r_addr;

endmodule

// File: tb/tb_router_fsm.sv
// Directed bench for router_fsm: steps one clock at a time and checks the
// Moore outputs and latched address against hand-computed state codes.
module tb_router_fsm;
  logic       clock = 1'b0;
  logic       resetn, pkt_valid, fifo_full, parity_done, low_pkt_valid;
  logic [1:0] data_in;
  logic       fifo_empty_0, fifo_empty_1, fifo_empty_2;
  logic       soft_reset_0, soft_reset_1, soft_reset_2;
  logic       detect_add, lfd_state, ld_state, laf_state, full_state;
  logic       write_enb_reg, rst_int_reg, busy;
  logic [1:0] addr;

  int checks = 0;
  int errors = 0;

  // Output vector order: detect, lfd, ld, full, laf, rst_int, wen, busy
  localparam logic [7:0] DA  = 8'b1000_0000;
  localparam logic [7:0] LFD = 8'b0100_0001;
  localparam logic [7:0] LD  = 8'b0010_0010;
  localparam logic [7:0] FUL = 8'b0001_0001;
  localparam logic [7:0] LAF = 8'b0000_1011;
  localparam logic [7:0] LP  = 8'b0000_0011;
  localparam logic [7:0] CPE = 8'b0000_0101;
  localparam logic [7:0] WTE = 8'b0000_0001;

  router_fsm dut (
    .clock(clock), .resetn(resetn), .pkt_valid(pkt_valid), .data_in(data_in),
    .fifo_full(fifo_full), .fifo_empty_0(fifo_empty_0), .fifo_empty_1(fifo_empty_1),
    .fifo_empty_2(fifo_empty_2), .soft_reset_0(soft_reset_0), .soft_reset_1(soft_reset_1),
    .soft_reset_2(soft_reset_2), .parity_done(parity_done), .low_pkt_valid(low_pkt_valid),
    .detect_add(detect_add), .lfd_state(lfd_state), .ld_state(ld_state),
    .laf_state(laf_state), .full_state(full_state), .write_enb_reg(write_enb_reg),
    .rst_int_reg(rst_int_reg), .busy(busy), .addr(addr)
  );

  always #5 clock = ~clock;

  task automatic step(input string tag, input logic [7:0] exp, input logic [1:0] exp_addr);
    logic [7:0] got;
    @(posedge clock);
    #1;
    got = {detect_add, lfd_state, ld_state, full_state, laf_state, rst_int_reg,
           write_enb_reg, busy};
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s outs: got=%b exp=%b", tag, got, exp);
    end
    checks++;
    assert (addr === exp_addr) else begin
      errors++;
      $error("FAIL %s addr: got=%0d exp=%0d", tag, addr, exp_addr);
    end
  endtask

  initial begin
    resetn = 1'b0; pkt_valid = 1'b0; data_in = 2'd0; fifo_full = 1'b0;
    parity_done = 1'b0; low_pkt_valid = 1'b0;
    fifo_empty_0 = 1'b1; fifo_empty_1 = 1'b1; fifo_empty_2 = 1'b1;
    soft_reset_0 = 1'b0; soft_reset_1 = 1'b0; soft_reset_2 = 1'b0;
    step("reset", DA, 2'd0);

    // Header to channel 1, payload, parity
    resetn = 1'b1; pkt_valid = 1'b1; data_in = 2'd1;
    step("hdr1_lfd", LFD, 2'd1);
    data_in = 2'd0;
    step("hdr1_ld", LD, 2'd1);
    step("ld_hold", LD, 2'd1);
    pkt_valid = 1'b0;
    step("lp", LP, 2'd1);
    step("cpe", CPE, 2'd1);
    step("cpe_to_da", DA, 2'd1);

    // Full for three cycles, then low_pkt_valid path to parity
    pkt_valid = 1'b1; data_in = 2'd0;
    step("hdr0_lfd", LFD, 2'd0);
    step("hdr0_ld", LD, 2'd0);
    fifo_full = 1'b1;
    step("full_1", FUL, 2'd0);
    step("full_2", FUL, 2'd0);
    step("full_3", FUL, 2'd0);
    fifo_full = 1'b0; low_pkt_valid = 1'b1;
    step("laf", LAF, 2'd0);
    step("laf_to_lp", LP, 2'd0);
    low_pkt_valid = 1'b0; pkt_valid = 1'b0;
    step("lp_to_cpe", CPE, 2'd0);
    step("cpe_da", DA, 2'd0);

    // LAF back to LD, then LAF with parity_done, then CPE with full
    pkt_valid = 1'b1;
    step("b_lfd", LFD, 2'd0);
    step("b_ld", LD, 2'd0);
    fifo_full = 1'b1;
    step("b_full", FUL, 2'd0);
    fifo_full = 1'b0;
    step("b_laf", LAF, 2'd0);
    step("laf_to_ld", LD, 2'd0);
    fifo_full = 1'b1;
    step("b_full2", FUL, 2'd0);
    fifo_full = 1'b0; parity_done = 1'b1;
    step("b_laf2", LAF, 2'd0);
    pkt_valid = 1'b0;
    step("laf_to_da", DA, 2'd0);
    parity_done = 1'b0; pkt_valid = 1'b1;
    step("c_lfd", LFD, 2'd0);
    step("c_ld", LD, 2'd0);
    pkt_valid = 1'b0; fifo_full = 1'b1;
    step("c_ld_full_prio", FUL, 2'd0);
    fifo_full = 1'b0;
    step("c_laf", LAF, 2'd0);
    low_pkt_valid = 1'b1;
    step("c_lp", LP, 2'd0);
    low_pkt_valid = 1'b0; fifo_full = 1'b1;
    step("c_cpe", CPE, 2'd0);
    step("cpe_to_full", FUL, 2'd0);
    fifo_full = 1'b0; soft_reset_0 = 1'b1;
    step("full_soft0", DA, 2'd0);
    soft_reset_0 = 1'b0;

    // Channel 2 busy: wait until empty; foreign soft reset ignored
    pkt_valid = 1'b1; data_in = 2'd2; fifo_empty_2 = 1'b0;
    step("wte", WTE, 2'd2);
    data_in = 2'd0;
    step("wte_hold", WTE, 2'd2);
    fifo_empty_2 = 1'b1;
    step("wte_lfd", LFD, 2'd2);
    step("wte_ld", LD, 2'd2);
    soft_reset_0 = 1'b1;
    step("soft_other", LD, 2'd2);
    soft_reset_0 = 1'b0; soft_reset_2 = 1'b1;
    step("soft_own", DA, 2'd2);
    soft_reset_2 = 1'b0;

    // Channel 0: soft_reset_1 ignored, soft_reset_0 aborts; address 3 ignored
    data_in = 2'd0;
    step("a0_lfd", LFD, 2'd0);
    step("a0_ld", LD, 2'd0);
    soft_reset_1 = 1'b1;
    step("a0_soft1", LD, 2'd0);
    soft_reset_1 = 1'b0; soft_reset_0 = 1'b1;
    step("a0_soft0", DA, 2'd0);
    soft_reset_0 = 1'b0; data_in = 2'd3;
    step("addr3_a", DA, 2'd0);
    step("addr3_b", DA, 2'd0);

    // Reset mid-packet in FIFO_FULL_STATE wins over soft reset
    data_in = 2'd1;
    step("r_lfd", LFD, 2'd1);
    step("r_ld", LD, 2'd1);
    fifo_full = 1'b1;
    step("r_full", FUL, 2'd1);
    resetn = 1'b0; soft_reset_0 = 1'b1;
    step("r_reset", DA, 2'd0);
    resetn = 1'b1; soft_reset_0 = 1'b0; fifo_full = 1'b0; pkt_valid = 1'b0;
    step("r_idle", DA, 2'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
